uart_tx_piso: RTL

UART_TX_PISO -- requirements
Module: uart_tx_piso

---
 rtl/uart_pkg.sv | 32 +++
 rtl/parity_gen.sv | 25 ++
 rtl/uart_tx_piso.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : uart_pkg                                                        |
// | Purpose  : Shared UART definitions: FSM state encoding, parity mode codes, |
// |            start/stop bit levels and a parity-enable helper. Used by the   |
// |            transmitter and intended for reuse by the receiver.             |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

  // ParityType codes; 2'b11 is treated as no parity as well.
  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  function automatic logic parity_enabled(input logic [1:0] mode);
    return (mode == PAR_ODD) || (mode == PAR_EVEN);
  endfunction

endpackage
`default_nettype wire

// File: rtl/parity_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : parity_gen                                                      |
// | Purpose  : Combinational parity bit generator for a UART data word.        |
// |            Even mode gives the XOR-reduce of the data, odd mode its        |
// |            complement. The output is meaningless in the no-parity modes.   |
// | Ports    : i_data   [DATA_W] data word                                     |
// |            i_mode   [2]      parity mode (PAR_* codes from uart_pkg)       |
// |            o_parity [1]      parity bit                                    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module parity_gen
  import uart_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] i_data,
  input  logic [1:0]        i_mode,
  output logic              o_parity
);

  assign o_parity = (^i_data) ^ (i_mode == PAR_ODD);

endmodule
`default_nettype wire

// File: rtl/uart_tx_piso.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : uart_tx_piso                                                    |
// | Purpose  : UART transmitter, parallel-in serial-out. Sends start bit,      |
// |            DATA_W data bits LSB first, optional parity bit and one stop    |
// |            bit, one bit per rising edge of BaudOut.                        |
// | Ports    : BaudOut    [1]      bit-rate clock                              |
// |            ResetN     [1]      asynchronous active-low reset               |
// |            DataIn     [DATA_W] parallel word to transmit                   |
// |            Send       [1]      transmit request, sampled only in IDLE      |
// |            ParityType [2]      00 none, 01 odd, 10 even, 11 none           |
// |            DataTx     [1]      serial line, idles high                     |
// |            Busy       [1]      high while a frame is in progress           |
// |            Done       [1]      one-cycle pulse after the stop bit          |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module uart_tx_piso
  import uart_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              BaudOut,
  input  logic              ResetN,
  input  logic [DATA_W-1:0] DataIn,
  input  logic              Send,
  input  logic [1:0]        ParityType,
  output logic              DataTx,
  output logic              Busy,
  output logic              Done
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  uart_state_t       r_state;
  uart_state_t       w_state_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_data;      // word latched at accept, feeds parity
  logic [DATA_W-1:0] r_shift;     // bit 0 holds the next data bit to drive
  logic [1:0]        r_par_type;
  logic              r_tx;
  logic              r_busy;
  logic              r_done;
  logic              w_parity;
  logic              w_last_bit;
  logic              w_accept;
  logic              w_tx_next;

  parity_gen #(
    .DATA_W (DATA_W)
  ) u_parity_gen (
    .i_data   (r_data),
    .i_mode   (r_par_type),
    .o_parity (w_parity)
  );

  assign w_accept   = (r_state == ST_IDLE) && Send;
  assign w_last_bit = (r_cnt == CNT_W'(DATA_W - 1));

  // The line is registered, so the value driven here is the level that
  // appears for the whole of the state being entered.
  always_comb begin
    w_state_next = r_state;
    w_tx_next    = STOP_BIT;
    case (r_state)
      ST_IDLE: begin
        if (Send) begin
          w_state_next = ST_START;
          w_tx_next    = START_BIT;
        end
      end
      ST_START: begin
        w_state_next = ST_DATA;
        w_tx_next    = r_shift[0];
      end
      ST_DATA: begin
        if (!w_last_bit) begin
          w_tx_next = r_shift[0];
        end else if (parity_enabled(r_par_type)) begin
          w_state_next = ST_PARITY;
          w_tx_next    = w_parity;
        end else begin
          w_state_next = ST_STOP;
        end
      end
      ST_PARITY: begin
        w_state_next = ST_STOP;
      end
      ST_STOP: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge BaudOut or negedge ResetN) begin
    if (!ResetN) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge BaudOut or negedge ResetN) begin
    if (!ResetN) begin
      r_tx       <= STOP_BIT;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_cnt      <= '0;
      r_data     <= '1;
      r_shift    <= '1;
      r_par_type <= '1;
    end else begin
      r_tx   <= w_tx_next;
      r_busy <= (w_state_next != ST_IDLE);
      // STOP always leads to IDLE, so this marks the first IDLE cycle.
      r_done <= (r_state == ST_STOP);

      if (w_accept) begin
        r_data     <= DataIn;
        r_shift    <= DataIn;
        r_par_type <= ParityType;
      end else if (w_state_next == ST_DATA) begin
        // Bit 0 was just loaded onto the line; expose the following bit.
        r_shift <= {1'b1, r_shift[DATA_W-1:1]};
      end

      if (r_state == ST_START) begin
        r_cnt <= '0;
      end else if (r_state == ST_DATA) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign DataTx = r_tx;
  assign Busy   = r_busy;
  assign Done   = r_done;

endmodule
`default_nettype wire
